digit_serial_addsub: RTL and testbench

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/addsub_pkg.sv | 14 +
 rtl/full_adder_array.sv | 23 ++
 rtl/digit_serial_addsub.sv | 144 ++++++++++++++
 tb/tb_digit_serial_addsub.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/subtract unit.
// Holds the FSM state encoding and the operation codes.
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_array.sv
// Combinational ADDER_WIDTH-bit ripple slice.
// Ports: a, b, cin in; sum, cout, cmsb (carry into the top bit) out.
module full_adder_array #(
  parameter int ADDER_WIDTH = 8
) (
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   cout,
  output logic                   cmsb
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b}
                + {{ADDER_WIDTH{1'b0}}, cin};
    // Carry into the top bit recovered from its sum bit.
    cmsb = sum[ADDER_WIDTH-1]
         ^ a[ADDER_WIDTH-1]
         ^ b[ADDER_WIDTH-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor, CHUNK bits per cycle.
// Ports: clk, rst (sync, high); in_* valid/ready operand side; out_* valid/ready result side.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW =
    (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             accept;
  logic             last;
  logic             is_sub;

  assign accept = (state_q == S_IDLE) && in_valid;
  assign last   = (idx_q == CW'(NCHUNK - 1));
  assign is_sub = (in_op == OP_SUB);

  full_adder_array #(
    .ADDER_WIDTH(CHUNK)
  ) u_slice (
    .a   (a_q[CHUNK-1:0]),
    .b   (b_q[CHUNK-1:0]),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout),
    .cmsb(slice_cmsb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)    state_d = S_RUN;
      S_RUN:  if (last)      state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b ^ {WIDTH{is_sub}};
      carry_d = is_sub;
      res_d   = '0;
      idx_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == S_RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      // New slice enters at the top; after NCHUNK
      // shifts the first slice sits at bit 0.
      res_d   = (res_q >> CHUNK)
              | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
      carry_d = slice_cout;
      idx_d   = idx_q + CW'(1);
      if (last) begin
        cout_d = slice_cout;
        ovf_d  = slice_cout ^ slice_cmsb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs: results gated to zero outside DONE
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    out_result = out_valid ? res_q : '0;
    out_cout   = out_valid & cout_q;
    out_ovf    = out_valid & ovf_q;
    out_zero   = out_valid & (res_q == '0);
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed self-checking bench for digit_serial_addsub.
// WIDTH=32, CHUNK=8: four slices per operation.
module tb_digit_serial_addsub;
  import addsub_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  digit_serial_addsub #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op from IDLE and wait for out_valid.
  // lat is edges after accept, -1 on timeout.
  task automatic run_op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        op,
    output int         lat
  );
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_result got %h want 0", out_result); end
    checks++; if ({out_cout, out_ovf, out_zero} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {out_cout, out_ovf, out_zero}); end
  endtask

  task automatic test_add_wrap;
    int lat;
    run_op(32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL add_result got %h want 00000000", out_result); end
    checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL add_cout got %b want 1", out_cout); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL add_zero got %b want 1", out_zero); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got %b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL drain_result got %h want 0", out_result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_sub_borrow;
    int lat;
    run_op(32'd5, 32'd7, OP_SUB, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got %0d want 4", lat); end
    checks++; if (out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result got %h want fffffffe", out_result); end
    checks++; if ({out_cout, out_ovf, out_zero} !== 3'b000) begin errors++; $display("FAIL sub_flags got %b want 000", {out_cout, out_ovf, out_zero}); end
    drain();
  endtask

  task automatic test_overflow;
    int lat;
    run_op(32'h8000_0000, 32'h1, OP_SUB, lat);
    checks++; if (out_result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL subovf_result got %h want 7fffffff", out_result); end
    checks++; if ({out_cout, out_ovf, out_zero} !== 3'b110) begin errors++; $display("FAIL subovf_flags got %b want 110", {out_cout, out_ovf, out_zero}); end
    drain();
    run_op(32'h7FFF_FFFF, 32'h1, OP_ADD, lat);
    checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL addovf_result got %h want 80000000", out_result); end
    checks++; if ({out_cout, out_ovf, out_zero} !== 3'b010) begin errors++; $display("FAIL addovf_flags got %b want 010", {out_cout, out_ovf, out_zero}); end
    drain();
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(32'h1234_5678, 32'h1111_1111, OP_ADD, lat);
    in_a = 32'h0000_0100; in_b = 32'h1;
    in_op = OP_SUB; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_result !== 32'h2345_6789) begin errors++; $display("FAIL bp_result[%0d] got %h want 23456789", i, out_result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_bubble got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got %b want 0", in_ready); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp2_latency got %0d want 4", lat); end
    checks++; if (out_result !== 32'h0000_00FF) begin errors++; $display("FAIL bp2_result got %h want 000000ff", out_result); end
    checks++; if ({out_cout, out_ovf, out_zero} !== 3'b100) begin errors++; $display("FAIL bp2_flags got %b want 100", {out_cout, out_ovf, out_zero}); end
    drain();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bit seen;
    @(negedge clk);
    in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555;
    in_op = OP_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_abort got %b want 0", seen); end
    run_op(32'h10, 32'h10, OP_SUB, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_rst_latency got %0d want 4", lat); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL post_rst_result got %h want 0", out_result); end
    checks++; if ({out_cout, out_ovf, out_zero} !== 3'b101) begin errors++; $display("FAIL post_rst_flags got %b want 101", {out_cout, out_ovf, out_zero}); end
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_op = OP_ADD; out_ready = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub_borrow();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
